// File: rtl/mdio_master_if.sv
// Command/response handshake bundle for the MDIO management master.
// The master modport is the command issuer; the slave modport is the MDIO engine.
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_c45;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_c45, cmd_op, cmd_phyad, cmd_regad, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_c45, cmd_op, cmd_phyad, cmd_regad, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mdio_master.sv
// MDIO/SMI management master: Clause-22 and optional Clause-45 frames, with a
// programmable MDC half-period and preamble length. One response per command.
module mdio_master #(
    parameter int HALF_PERIOD  = 25,
    parameter int PREAMBLE_LEN = 32,
    parameter bit C45_EN       = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    mdio_master_if.slave bus,
    output logic         mdc,
    output logic         mdd_o,
    output logic         mdd_oe,
    input  logic         mdd_i,
    output logic         busy
);
    localparam int                TICK_W    = $clog2(HALF_PERIOD);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, RESP} state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [4:0]        bit_cnt;    // bits left in the current field after this one
    logic [31:0]       frame_sr;   // ST..DATA, next bit to send at [31]
    logic [15:0]       rd_sr;
    logic              is_read;
    logic              ta_err;
    logic              cmd_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [15:0]       rsp_data;
    logic              cmd_illegal;
    logic [31:0]       cmd_frame;

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_err   = rsp_err;

    // Decode the offered command: legality and its 32-bit post-preamble bit image.
    // Every legal read op has op[1]=1; read frames carry 1s where the PHY drives.
    always_comb begin
        cmd_illegal = bus.cmd_c45 ? !C45_EN
                                  : (bus.cmd_op == 2'b00 || bus.cmd_op == 2'b11);
        if (bus.cmd_op[1]) begin
            cmd_frame = {1'b0, !bus.cmd_c45, bus.cmd_op, bus.cmd_phyad, bus.cmd_regad,
                         18'h3FFFF};
        end else begin
            cmd_frame = {1'b0, !bus.cmd_c45, bus.cmd_op, bus.cmd_phyad, bus.cmd_regad,
                         2'b10, bus.cmd_data};
        end
    end

    // Frame sequencer: MDC divider, bit shifting, read capture, response handshake.
    // NOTE: RST is asynchronous so a mid-frame reset releases the bus at once;
    // every state register uses <= so all updates see pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            frame_sr  <= '0;
            rd_sr     <= '0;
            is_read   <= 1'b0;
            ta_err    <= 1'b0;
            mdc       <= 1'b0;
            mdd_o     <= 1'b1;
            mdd_oe    <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        tick      <= '0;
                        mdc       <= 1'b0;
                        is_read   <= bus.cmd_op[1];
                        ta_err    <= 1'b0;
                        rd_sr     <= '0;
                        frame_sr  <= cmd_frame;
                        if (cmd_illegal) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else if (PREAMBLE_LEN > 0) begin
                            state   <= PRE;
                            bit_cnt <= 5'(PREAMBLE_LEN - 1);
                            mdd_o   <= 1'b1;
                            mdd_oe  <= 1'b1;
                        end else begin
                            state    <= HDR;
                            bit_cnt  <= 5'd13;
                            mdd_o    <= cmd_frame[31];
                            mdd_oe   <= 1'b1;
                            frame_sr <= {cmd_frame[30:0], 1'b0};
                        end
                    end
                end

                PRE, HDR, TA, DATA: begin
                    if (tick != TICK_LAST) begin
                        tick <= tick + 1'b1;
                    end else begin
                        tick <= '0;
                        mdc  <= !mdc;
                        if (!mdc) begin
                            // Rising MDC: sample what the PHY is driving.
                            if (is_read && state == TA && bit_cnt == 5'd0) ta_err <= mdd_i;
                            if (is_read && state == DATA) rd_sr <= {rd_sr[14:0], mdd_i};
                        end else if (bit_cnt != 5'd0) begin
                            // Falling MDC inside a field: present the next bit.
                            bit_cnt <= bit_cnt - 1'b1;
                            if (state != PRE) begin
                                mdd_o    <= frame_sr[31];
                                frame_sr <= {frame_sr[30:0], 1'b0};
                            end
                        end else begin
                            // Falling MDC at a field boundary.
                            case (state)
                                PRE: begin
                                    state    <= HDR;
                                    bit_cnt  <= 5'd13;
                                    mdd_o    <= frame_sr[31];
                                    frame_sr <= {frame_sr[30:0], 1'b0};
                                end
                                HDR: begin
                                    state    <= TA;
                                    bit_cnt  <= 5'd1;
                                    mdd_o    <= frame_sr[31];
                                    mdd_oe   <= !is_read;
                                    frame_sr <= {frame_sr[30:0], 1'b0};
                                end
                                TA: begin
                                    state    <= DATA;
                                    bit_cnt  <= 5'd15;
                                    mdd_o    <= frame_sr[31];
                                    frame_sr <= {frame_sr[30:0], 1'b0};
                                end
                                default: begin
                                    state     <= RESP;
                                    mdd_o     <= 1'b1;
                                    mdd_oe    <= 1'b0;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= is_read ? rd_sr : 16'h0000;
                                    rsp_err   <= ta_err;
                                end
                            endcase
                        end
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: two instances (32-bit and suppressed
// preamble), a bench-side PHY, and a frame-level reference model.
module tb_mdio_master;
    localparam int HP    = 2;
    localparam int PRE_A = 32;
    localparam int PRE_B = 0;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mdio_master_if ifa ();
    mdio_master_if ifb ();

    logic        sel = 1'b0;   // 0 selects dut_a, 1 selects dut_b
    logic        cmd_valid = 1'b0;
    logic        cmd_c45 = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_phyad = '0;
    logic [4:0]  cmd_regad = '0;
    logic [15:0] cmd_data = '0;
    logic        rsp_ready = 1'b0;
    logic        mdd_i = 1'b1;

    logic mdc_a, mdd_o_a, mdd_oe_a, busy_a;
    logic mdc_b, mdd_o_b, mdd_oe_b, busy_b;

    assign ifa.cmd_valid = cmd_valid & ~sel;
    assign ifb.cmd_valid = cmd_valid & sel;
    assign ifa.rsp_ready = rsp_ready & ~sel;
    assign ifb.rsp_ready = rsp_ready & sel;
    assign ifa.cmd_c45 = cmd_c45;     assign ifb.cmd_c45 = cmd_c45;
    assign ifa.cmd_op = cmd_op;       assign ifb.cmd_op = cmd_op;
    assign ifa.cmd_phyad = cmd_phyad; assign ifb.cmd_phyad = cmd_phyad;
    assign ifa.cmd_regad = cmd_regad; assign ifb.cmd_regad = cmd_regad;
    assign ifa.cmd_data = cmd_data;   assign ifb.cmd_data = cmd_data;

    mdio_master #(.HALF_PERIOD(HP), .PREAMBLE_LEN(PRE_A), .C45_EN(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .bus(ifa.slave),
        .mdc(mdc_a), .mdd_o(mdd_o_a), .mdd_oe(mdd_oe_a), .mdd_i(mdd_i), .busy(busy_a)
    );

    mdio_master #(.HALF_PERIOD(HP), .PREAMBLE_LEN(PRE_B), .C45_EN(1'b1)) dut_b (
        .CLK(CLK), .RST(RST), .bus(ifb.slave),
        .mdc(mdc_b), .mdd_o(mdd_o_b), .mdd_oe(mdd_oe_b), .mdd_i(mdd_i), .busy(busy_b)
    );

    logic        mdc_s, mdd_o_s, mdd_oe_s, busy_s, cmd_ready_s, rsp_valid_s, rsp_err_s;
    logic [15:0] rsp_data_s;
    assign mdc_s       = sel ? mdc_b : mdc_a;
    assign mdd_o_s     = sel ? mdd_o_b : mdd_o_a;
    assign mdd_oe_s    = sel ? mdd_oe_b : mdd_oe_a;
    assign busy_s      = sel ? busy_b : busy_a;
    assign cmd_ready_s = sel ? ifb.cmd_ready : ifa.cmd_ready;
    assign rsp_valid_s = sel ? ifb.rsp_valid : ifa.rsp_valid;
    assign rsp_err_s   = sel ? ifb.rsp_err : ifa.rsp_err;
    assign rsp_data_s  = sel ? ifb.rsp_data : ifa.rsp_data;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Both instances have Clause-45 enabled, so only C22 ops 00/11 are illegal.
    function automatic bit is_illegal(input bit c45, input logic [1:0] op);
        return !c45 && (op == 2'b00 || op == 2'b11);
    endfunction

    // Issue one command and follow it to its consumed response.
    // mode (reads only): 0 = no PHY, 1 = PHY with TA2=0, 2 = PHY with TA2=1.
    task automatic do_cmd(input bit s, input bit c45, input logic [1:0] op,
                          input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d,
                          input int mode, input logic [15:0] pd, input int hold);
        int          pre, nbits, lat, rises, k;
        bit          ill, rd, prev_mdc, any_oe, stable;
        logic [63:0] ones, exp_o, exp_oe, obs_o, obs_oe, phy_vec;
        logic [31:0] tail;
        logic [15:0] exp_data;
        bit          exp_err;

        pre   = s ? PRE_B : PRE_A;
        nbits = pre + 32;
        ill   = is_illegal(c45, op);
        rd    = op[1];
        ones  = (nbits >= 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
        tail  = {1'b0, ~c45, op, pa, ra, 2'b10, d};
        exp_o = (ones & 64'hFFFF_FFFF_0000_0000) | {32'h0, tail};
        exp_oe = rd ? (ones & ~64'h3_FFFF) : ones;
        phy_vec = {64{1'b1}};
        if (rd) begin
            phy_vec[16] = (mode == 1) ? 1'b0 : 1'b1;
            if (mode != 0) phy_vec[15:0] = pd;
        end
        if (ill) begin
            exp_data = 16'h0000;
            exp_err  = 1'b1;
        end else begin
            exp_data = rd ? ((mode == 0) ? 16'hFFFF : pd) : 16'h0000;
            exp_err  = rd && (mode != 1);
        end

        @(negedge CLK);
        sel = s;
        mdd_i = phy_vec[nbits-1];
        cmd_c45 = c45; cmd_op = op; cmd_phyad = pa; cmd_regad = ra; cmd_data = d;
        cmd_valid = 1'b1;
        check("idle_ready", cmd_ready_s, 1'b1);
        @(negedge CLK);
        cmd_valid = 1'b0;
        check("accept", {busy_s, cmd_ready_s, mdd_oe_s}, {1'b1, 1'b0, ~ill});

        lat = 0; rises = 0; k = 0; prev_mdc = mdc_s; any_oe = mdd_oe_s;
        obs_o = '0; obs_oe = '0;
        while (!rsp_valid_s && lat < 2000) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (mdd_oe_s) any_oe = 1'b1;
            if (mdc_s && !prev_mdc) begin
                obs_o  = {obs_o[62:0], mdd_o_s};
                obs_oe = {obs_oe[62:0], mdd_oe_s};
                rises++;
                k++;
                mdd_i = (k < nbits) ? phy_vec[nbits-1-k] : 1'b1;
            end
            prev_mdc = mdc_s;
        end
        mdd_i = 1'b1;

        check("latency", lat, ill ? 0 : nbits * 2 * HP);
        if (ill) begin
            check("ill_no_mdc", rises, 0);
            check("ill_no_oe", any_oe, 1'b0);
        end else begin
            check("mdc_bits", rises, nbits);
            check("mdd_o_bits", obs_o & exp_oe, exp_o & exp_oe);
            check("mdd_oe_bits", obs_oe, exp_oe);
            check("end_idle_pins", {mdc_s, mdd_oe_s}, 2'b00);
        end
        check("rsp", {rsp_valid_s, rsp_err_s, rsp_data_s}, {1'b1, exp_err, exp_data});

        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op = 2'($urandom_range(0, 3));
            @(posedge CLK);
            @(negedge CLK);
            if (rsp_valid_s !== 1'b1 || rsp_err_s !== exp_err || rsp_data_s !== exp_data ||
                cmd_ready_s !== 1'b0 || busy_s !== 1'b1 || mdc_s !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) check("rsp_hold", stable, 1'b1);

        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check("consume", {busy_s, cmd_ready_s, rsp_valid_s}, 3'b010);
    endtask

    initial begin
        bit seen;
        #12;
        check("reset_a", {mdc_a, mdd_o_a, mdd_oe_a, ifa.cmd_ready, ifa.rsp_valid,
                          ifa.rsp_data, ifa.rsp_err, busy_a},
                         {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
        check("reset_b", {mdc_b, mdd_oe_b, ifb.cmd_ready, ifb.rsp_valid, busy_b}, 5'b00100);
        @(negedge CLK);
        RST = 1'b0;

        // Directed frames.
        do_cmd(1'b0, 1'b0, 2'b01, 5'd5, 5'd0, 16'h1140, 0, 16'h0000, 0);
        do_cmd(1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 16'h0000, 1, 16'h0141, 0);
        do_cmd(1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 16'h0000, 0, 16'h0000, 0);
        do_cmd(1'b1, 1'b1, 2'b00, 5'd3, 5'd1, 16'h0007, 0, 16'h0000, 0);
        do_cmd(1'b1, 1'b1, 2'b11, 5'd3, 5'd1, 16'h0000, 1, 16'hBEEF, 0);
        do_cmd(1'b0, 1'b0, 2'b00, 5'd4, 5'd4, 16'h1234, 0, 16'h0000, 0);
        do_cmd(1'b1, 1'b0, 2'b01, 5'd9, 5'd17, 16'hA5C3, 0, 16'h0000, 20);

        // Randomized frames.
        for (int n = 0; n < 30; n++) begin
            do_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 16'($urandom),
                   int'($urandom_range(0, 2)), 16'($urandom), int'($urandom_range(0, 4)));
        end

        // Reset in the middle of the PHYAD field of a C22 read on dut_a.
        @(negedge CLK);
        sel = 1'b0;
        cmd_c45 = 1'b0; cmd_op = 2'b10; cmd_phyad = 5'd3; cmd_regad = 5'd4;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        repeat ((PRE_A + 6) * 2 * HP + HP) @(negedge CLK);
        check("pre_rst_state", {busy_a, mdc_a, mdd_oe_a}, 3'b111);
        #2 RST = 1'b1;
        #1;
        check("rst_async", {mdc_a, mdd_oe_a, mdd_o_a, ifa.cmd_ready, busy_a, ifa.rsp_valid},
                           6'b001100);
        @(negedge CLK);
        RST = 1'b0;
        seen = 1'b0;
        repeat (300) begin
            @(negedge CLK);
            if (ifa.rsp_valid || mdc_a || busy_a) seen = 1'b1;
        end
        check("no_rsp_after_rst", seen, 1'b0);
        check("ready_after_rst", ifa.cmd_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Parametrised MDIO/SMI management master that drives the PHY management pins (mdio_mdc, mdio_mdd) of the Ethernet PHY on the N210 and later platforms.
- Supports Clause-22 and, when enabled, Clause-45 frames.
- Programmable MDC rate and preamble length.
- Exchanges commands and responses over a valid/ready handshake.
- The platform top splits mdio_mdd into a tristate built from mdd_o/mdd_oe/mdd_i.

Parameters:
- HALF_PERIOD, 25, CLK cycles per MDC half-period; must be >=2 (25 at 100 MHz gives a 2 MHz MDC).
- PREAMBLE_LEN, 32, number of preamble '1' bits, range 0..32; 0 means preamble suppressed.
- C45_EN, 1, 1 enables Clause-45 ops; 0 makes any cmd_c45=1 command illegal.

Ports:
- CLK  in  1  sole clock.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_c45  in  1  0 = Clause-22 frame, 1 = Clause-45 frame.
- cmd_op  in  2  C22: 01 write, 10 read. C45: 00 address, 01 write, 11 read, 10 read-post-increment.
- cmd_phyad  in  5  PHY address (C45: port address).
- cmd_regad  in  5  register address (C45: DEVAD).
- cmd_data  in  16  write data or C45 address.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
- rsp_data  out  16  read data; 0x0000 for writes and address frames.
- rsp_err  out  1  TA error or illegal command.
- mdc  out  1  management clock.
- mdd_o  out  1  MDIO output data.
- mdd_oe  out  1  MDIO output enable.
- mdd_i  in  1  MDIO input.
- busy  out  1  high from command accept until response consumed.

Behaviour:
- Reset values: mdc=0, mdd_o=1, mdd_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, state IDLE.
- Reset is asynchronous: an RST mid-frame aborts the frame, produces no response, and forces all reset values immediately.
- States: IDLE -> PRE -> HDR -> TA -> DATA -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch all cmd fields, then set cmd_ready=0 and busy=1.
  - Illegal command (cmd_c45=0 with op 00 or 11; cmd_op 00 with cmd_c45=0 treated illegal; or cmd_c45=1 with C45_EN=0): go straight to RESP on the next cycle with rsp_err=1 and rsp_data=0. No MDC activity.
- Bit timing:
  - A tick counter runs 0..HALF_PERIOD-1; mdc toggles at each terminal count.
  - Each frame bit occupies one low half followed by one high half.
  - mdd_o/mdd_oe change only on the cycle mdc goes low; the first bit is presented on the cycle after accept.
  - mdd_i is sampled on the cycle mdc goes 0->1.
- PRE: PREAMBLE_LEN bits of '1' with mdd_oe=1; skipped when PREAMBLE_LEN=0.
- HDR (14 bits, MSB first):
  - ST: 01 for C22, 00 for C45.
  - OP: C22 write=01, read=10; C45 op field sent verbatim.
  - Then PHYAD[4:0], then REGAD/DEVAD[4:0].
- TA (2 bits):
  - Write/address frames drive 1,0.
  - Read frames set mdd_oe=0 for both bits. Sample the second TA bit; if it is not 0, set rsp_err=1, but data is still captured.
- DATA (16 bits, MSB first):
  - Write/address frames drive cmd_data.
  - Read frames keep mdd_oe=0 and shift in mdd_i.
- End of frame:
  - After the last bit's high half, mdc returns low and mdd_oe=0.
  - Enter RESP with rsp_valid=1.
  - Frame length is (PREAMBLE_LEN+32) bits, i.e. (PREAMBLE_LEN+32)*2*HALF_PERIOD cycles from first bit to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_err hold stable until rsp_ready.
  - On consume, go to IDLE with busy=0 and cmd_ready=1 in the same cycle.
  - cmd_valid is ignored while in RESP.
- Exactly one response per accepted command.
- C45 read-post-increment is framed like a read; the PHY handles the increment.

Test Plan:
- C22 write, HALF_PERIOD=2, PREAMBLE_LEN=32, phyad=5, regad=0, data=0x1140 -> at mdc rising edges mdd_o = 32×'1', 01, 01, 00101, 00000, 10, 0001000101000000; mdd_oe=1 throughout; rsp_valid after 256 cycles; rsp_err=0, rsp_data=0.
- C22 read phyad=1, regad=2; bench PHY drives TA2=0 and data 0x0141 -> rsp_data=0x0141, rsp_err=0; mdd_oe=0 for the last 18 bit periods.
- C22 read with no PHY (mdd_i held 1) -> rsp_data=0xFFFF, rsp_err=1.
- C45 address (op 00, devad=1, data=0x0007) then C45 read (op 11) with PREAMBLE_LEN=0 -> frames begin 00 00 and 00 11; each frame is 32 bits = 128 cycles; read returns the bench value.
- Illegal C22 op 00 -> mdc never toggles; rsp_valid=1 one cycle after accept with rsp_err=1; mdd_oe stays 0.
- Hold rsp_ready low 20 cycles -> rsp fields stable, cmd_ready=0, busy=1. Then a second frame with RST pulsed mid-HDR -> mdc=0 and mdd_oe=0 immediately; after RST falls, cmd_ready=1 and no rsp_valid appears.
